// File: rtl/vcount.sv
// ---------------------------------------------------------------------------
// vcount -- vertical line counter for the VGA controller.
//
// A free-running counter that steps once per rising Clock edge (one edge is
// one horizontal line in the top level). It sweeps one full frame of
// V_TOTAL lines: display, front porch, sync pulse and back porch. It then
// wraps to 0. The current line is decoded into four mutually exclusive
// region flags.
//
// Ports:
//   Clock    in   rising-edge clock, one edge = one line
//   Clear    in   asynchronous active-high reset (forces Q = 0 at once)
//   Q        out  [WIDTH-1:0] current line number, 0 .. V_TOTAL-1 (registered)
//   R        out  high while Q is in the display region
//   R_S      out  high while Q is in the front porch
//   R_S_P    out  high while Q is in the sync pulse (active-high polarity)
//   R_S_P_Q  out  high while Q is in the back porch
//
// The flags are combinational decodes of the Q register and have no added
// latency. Consumers are expected to register them.
// ---------------------------------------------------------------------------
module vcount #(
  parameter int WIDTH     = 10,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic             Clock,
  input  logic             Clear,
  output logic [WIDTH-1:0] Q,
  output logic             R,
  output logic             R_S,
  output logic             R_S_P,
  output logic             R_S_P_Q
);

  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Legality: every region needs at least one line, and the frame must fit
  // in the counter.
  if (V_DISPLAY < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_region
    $error("vcount: every vertical region must be at least one line");
  end
  if (longint'(V_TOTAL) > (longint'(1) << WIDTH)) begin : g_bad_width
    $error("vcount: V_TOTAL does not fit in WIDTH bits");
  end

  // Region start lines. All of them are <= V_TOTAL-1, so they fit in WIDTH
  // bits even when V_TOTAL is exactly 2**WIDTH.
  localparam logic [WIDTH-1:0] FRONT_START = WIDTH'(V_DISPLAY);
  localparam logic [WIDTH-1:0] SYNC_START  = WIDTH'(V_DISPLAY + V_FRONT);
  localparam logic [WIDTH-1:0] BACK_START  = WIDTH'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [WIDTH-1:0] LAST_LINE   = WIDTH'(V_TOTAL - 1);

  // Line counter. The explicit wrap at LAST_LINE means values at or above
  // V_TOTAL can never be reached, even when WIDTH has spare range.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      Q <= '0;
    end else if (Q == LAST_LINE) begin
      Q <= '0;
    end else begin
      Q <= Q + WIDTH'(1);
    end
  end

  // Region decode. The regions tile 0 .. LAST_LINE, so exactly one flag is
  // high. The back-porch flag needs no upper bound because Q never passes
  // LAST_LINE.
  always_comb begin
    R       = (Q < FRONT_START);
    R_S     = (Q >= FRONT_START) && (Q < SYNC_START);
    R_S_P   = (Q >= SYNC_START)  && (Q < BACK_START);
    R_S_P_Q = (Q >= BACK_START);
  end

endmodule

// File: tb/tb_vcount.sv
// ---------------------------------------------------------------------------
// tb_vcount -- directed self-checking bench for vcount (default 525-line
// frame). Each scenario task drives Clock/Clear activity and checks values
// it computed by hand. A negedge monitor checks the one-hot and range
// invariants every cycle.
// ---------------------------------------------------------------------------
module tb_vcount;

  logic       Clock;
  logic       Clear;
  logic [9:0] Q;
  logic       R;
  logic       R_S;
  logic       R_S_P;
  logic       R_S_P_Q;

  int tests_run = 0;
  int failed    = 0;

  vcount dut (
    .Clock   (Clock),
    .Clear   (Clear),
    .Q       (Q),
    .R       (R),
    .R_S     (R_S),
    .R_S_P   (R_S_P),
    .R_S_P_Q (R_S_P_Q)
  );

  // Clock and reset: the period is 10. Posedges fall at 5, 15, 25, ...
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Per-cycle invariants: the flags are one-hot and defined, and Q < 525.
  always @(negedge Clock) begin
    tests_run++;
    if ($isunknown({R, R_S, R_S_P, R_S_P_Q}) || $countones({R, R_S, R_S_P, R_S_P_Q}) != 1) begin
      failed++;
      $display("FAIL onehot at t=%0t: got flags %b expected exactly one high", $time,
               {R, R_S, R_S_P, R_S_P_Q});
    end
    tests_run++;
    if ($isunknown(Q) || Q >= 10'd525) begin
      failed++;
      $display("FAIL q_range at t=%0t: got %0d expected < 525", $time, Q);
    end
  end

  // Advance one line and settle just after the active edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Clear = 1'b1;
    #1;
    Clear = 1'b0;
    #1;
    tests_run++;
    if (Q !== 10'd0) begin
      failed++;
      $display("FAIL reset_q: got %0d expected 0", Q);
    end
    tests_run++;
    if ({R, R_S, R_S_P, R_S_P_Q} !== 4'b1000) begin
      failed++;
      $display("FAIL reset_flags: got %b expected 1000", {R, R_S, R_S_P, R_S_P_Q});
    end
    tick();
    tests_run++;
    if (Q !== 10'd1) begin
      failed++;
      $display("FAIL release_first_edge: got %0d expected 1", Q);
    end
  endtask

  // Q starts at 1. It takes 478 more edges to reach 479, then one edge to 480.
  task automatic test_display_boundary();
    repeat (478) tick();
    tests_run++;
    if (Q !== 10'd479 || {R, R_S, R_S_P, R_S_P_Q} !== 4'b1000) begin
      failed++;
      $display("FAIL last_display: got q=%0d flags=%b expected q=479 flags=1000",
               Q, {R, R_S, R_S_P, R_S_P_Q});
    end
    tick();
    tests_run++;
    if (Q !== 10'd480 || {R, R_S, R_S_P, R_S_P_Q} !== 4'b0100) begin
      failed++;
      $display("FAIL front_start: got q=%0d flags=%b expected q=480 flags=0100",
               Q, {R, R_S, R_S_P, R_S_P_Q});
    end
  endtask

  // Q starts at 480. Covers the front-to-sync and sync-to-back edges and the sync width.
  task automatic test_sync_regions();
    int sync_cnt;
    repeat (9) tick();
    tests_run++;
    if (Q !== 10'd489 || {R, R_S, R_S_P, R_S_P_Q} !== 4'b0100) begin
      failed++;
      $display("FAIL last_front: got q=%0d flags=%b expected q=489 flags=0100",
               Q, {R, R_S, R_S_P, R_S_P_Q});
    end
    tick();
    tests_run++;
    if (Q !== 10'd490 || {R, R_S, R_S_P, R_S_P_Q} !== 4'b0010) begin
      failed++;
      $display("FAIL sync_start: got q=%0d flags=%b expected q=490 flags=0010",
               Q, {R, R_S, R_S_P, R_S_P_Q});
    end
    sync_cnt = int'(R_S_P);
    tick();
    sync_cnt += int'(R_S_P);
    tick();
    tests_run++;
    if (Q !== 10'd492 || {R, R_S, R_S_P, R_S_P_Q} !== 4'b0001) begin
      failed++;
      $display("FAIL back_start: got q=%0d flags=%b expected q=492 flags=0001",
               Q, {R, R_S, R_S_P, R_S_P_Q});
    end
    tests_run++;
    if (sync_cnt != 2) begin
      failed++;
      $display("FAIL sync_width: got %0d expected 2", sync_cnt);
    end
  endtask

  // Q starts at 492. It reaches 524 after 32 edges, then wraps to 0.
  task automatic test_wrap();
    repeat (32) tick();
    tests_run++;
    if (Q !== 10'd524 || {R, R_S, R_S_P, R_S_P_Q} !== 4'b0001) begin
      failed++;
      $display("FAIL last_line: got q=%0d flags=%b expected q=524 flags=0001",
               Q, {R, R_S, R_S_P, R_S_P_Q});
    end
    tick();
    tests_run++;
    if (Q !== 10'd0 || {R, R_S, R_S_P, R_S_P_Q} !== 4'b1000) begin
      failed++;
      $display("FAIL wrap: got q=%0d flags=%b expected q=0 flags=1000",
               Q, {R, R_S, R_S_P, R_S_P_Q});
    end
  endtask

  // Q starts at 0. Runs two full frames (checking per-frame flag counts), then 50 more edges.
  task automatic test_full_frames();
    int c_r, c_s, c_p, c_q;
    for (int f = 0; f < 2; f++) begin
      c_r = 0; c_s = 0; c_p = 0; c_q = 0;
      for (int i = 0; i < 525; i++) begin
        tick();
        c_r += int'(R);
        c_s += int'(R_S);
        c_p += int'(R_S_P);
        c_q += int'(R_S_P_Q);
      end
      tests_run++;
      if (Q !== 10'd0 || R !== 1'b1) begin
        failed++;
        $display("FAIL frame%0d_end: got q=%0d r=%b expected q=0 r=1", f, Q, R);
      end
      tests_run++;
      if (c_r != 480 || c_s != 10 || c_p != 2 || c_q != 33) begin
        failed++;
        $display("FAIL frame%0d_counts: got %0d/%0d/%0d/%0d expected 480/10/2/33",
                 f, c_r, c_s, c_p, c_q);
      end
    end
    repeat (50) tick();
    tests_run++;
    if (Q !== 10'd50 || {R, R_S, R_S_P, R_S_P_Q} !== 4'b1000) begin
      failed++;
      $display("FAIL after_1100: got q=%0d flags=%b expected q=50 flags=1000",
               Q, {R, R_S, R_S_P, R_S_P_Q});
    end
  endtask

  // Q starts at 50. Asserts Clear between edges at Q=300, holds it, then releases.
  task automatic test_mid_clear();
    repeat (250) tick();
    tests_run++;
    if (Q !== 10'd300) begin
      failed++;
      $display("FAIL pre_clear_q: got %0d expected 300", Q);
    end
    #3;
    Clear = 1'b1;
    #1;
    tests_run++;
    if (Q !== 10'd0 || {R, R_S, R_S_P, R_S_P_Q} !== 4'b1000) begin
      failed++;
      $display("FAIL async_clear: got q=%0d flags=%b expected q=0 flags=1000",
               Q, {R, R_S, R_S_P, R_S_P_Q});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (Q !== 10'd0 || R !== 1'b1) begin
        failed++;
        $display("FAIL clear_hold%0d: got q=%0d r=%b expected q=0 r=1", i, Q, R);
      end
    end
    #2;
    Clear = 1'b0;
    #1;
    tests_run++;
    if (Q !== 10'd0) begin
      failed++;
      $display("FAIL clear_release_q: got %0d expected 0", Q);
    end
    tick();
    tests_run++;
    if (Q !== 10'd1 || R !== 1'b1) begin
      failed++;
      $display("FAIL resume: got q=%0d r=%b expected q=1 r=1", Q, R);
    end
    tick();
    tests_run++;
    if (Q !== 10'd2) begin
      failed++;
      $display("FAIL resume_second: got %0d expected 2", Q);
    end
  endtask

  initial begin
    test_reset();
    test_display_boundary();
    test_sync_regions();
    test_wrap();
    test_full_frames();
    test_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
